// File: rtl/freq_bcd_formatter.sv
// rtl/freq_bcd_formatter.sv - binary Hz to auto-ranged 8-digit BCD display feeder
module freq_bcd_formatter #(
    parameter int IN_W = 32
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [IN_W-1:0] freq_in,
    input  logic            freq_valid,
    output logic [31:0]     Disp_Data,
    output logic [2:0]      point_1,
    output logic [2:0]      point_2,
    output logic            khz_mode,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, SHIFT, RANGE, OUT} state_t;

    localparam logic [5:0] LAST_BIT = 6'(IN_W - 1);

    state_t            state, state_next;
    logic [IN_W-1:0]   shift_reg;
    logic [39:0]       bcd;
    logic [39:0]       bcd_adj;
    logic [5:0]        bit_cnt;
    logic              pend_full;
    logic [IN_W-1:0]   pend_data;
    logic [31:0]       sel_data;
    logic [2:0]        sel_p1;
    logic [2:0]        sel_p2;
    logic              sel_khz;

    function automatic logic [39:0] dabble_adj(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int i = 0; i < 10; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = dabble_adj(bcd);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (freq_valid || pend_full) state_next = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_next = RANGE;
            RANGE:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            pend_full <= 1'b0;
            pend_data <= '0;
            sel_data  <= '0;
            sel_p1    <= 3'd0;
            sel_p2    <= 3'd4;
            sel_khz   <= 1'b0;
            Disp_Data <= '0;
            point_1   <= 3'd0;
            point_2   <= 3'd4;
            khz_mode  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // A strobe outside IDLE parks in the one-deep slot; newest value wins.
            if (state != IDLE && freq_valid) begin
                pend_full <= 1'b1;
                pend_data <= freq_in;
            end
            case (state)
                IDLE: begin
                    if (pend_full || freq_valid) begin
                        shift_reg <= pend_full ? pend_data : freq_in;
                        bcd       <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                    if (pend_full) begin
                        pend_full <= freq_valid;
                        if (freq_valid)
                            pend_data <= freq_in;
                    end
                end
                SHIFT: begin
                    bcd       <= (bcd_adj << 1) | {39'd0, shift_reg[IN_W-1]};
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + 6'd1;
                end
                RANGE: begin
                    if (bcd[39:36] != 4'd0) begin
                        sel_data <= bcd[39:8];
                        sel_p1   <= 3'd1;
                        sel_p2   <= 3'd0;
                        sel_khz  <= 1'b1;
                    end else if (bcd[35:32] != 4'd0) begin
                        sel_data <= bcd[35:4];
                        sel_p1   <= 3'd2;
                        sel_p2   <= 3'd1;
                        sel_khz  <= 1'b1;
                    end else begin
                        sel_data <= bcd[31:0];
                        sel_p1   <= 3'd0;
                        sel_p2   <= 3'd4;
                        sel_khz  <= 1'b0;
                    end
                end
                OUT: begin
                    Disp_Data <= sel_data;
                    point_1   <= sel_p1;
                    point_2   <= sel_p2;
                    khz_mode  <= sel_khz;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_bcd_formatter.sv
// tb/tb_freq_bcd_formatter.sv - directed self-checking bench for freq_bcd_formatter
module tb_freq_bcd_formatter;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] freq_in;
    logic        freq_valid;
    logic [31:0] Disp_Data;
    logic [2:0]  point_1;
    logic [2:0]  point_2;
    logic        khz_mode;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    freq_bcd_formatter #(.IN_W(32)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .freq_in    (freq_in),
        .freq_valid (freq_valid),
        .Disp_Data  (Disp_Data),
        .point_1    (point_1),
        .point_2    (point_2),
        .khz_mode   (khz_mode),
        .busy       (busy),
        .done       (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one value so it is sampled on the next rising edge; returns at the falling edge after it.
    task automatic pulse(input logic [31:0] v);
        @(negedge Clk);
        freq_in    = v;
        freq_valid = 1'b1;
        @(negedge Clk);
        freq_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] v, input logic [31:0] exp_data,
                           input logic [2:0] exp_p1, input logic [2:0] exp_p2, input logic exp_khz);
        int n;
        logic busy_ok;
        pulse(v);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge Clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd34);
        check({tag, "_busy_hold"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_data"}, Disp_Data, exp_data);
        check({tag, "_p1"}, {29'd0, point_1}, {29'd0, exp_p1});
        check({tag, "_p2"}, {29'd0, point_2}, {29'd0, exp_p2});
        check({tag, "_khz"}, {31'd0, khz_mode}, {31'd0, exp_khz});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge Clk);
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        @(negedge Clk);
    endtask

    initial begin
        int n;
        int done_cnt;
        int t1;
        int t2;
        logic [31:0] d1;
        logic [31:0] d2;

        Reset_n    = 1'b0;
        freq_in    = '0;
        freq_valid = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        check("rst_data", Disp_Data, 32'h0);
        check("rst_p1", {29'd0, point_1}, 32'd0);
        check("rst_p2", {29'd0, point_2}, 32'd4);
        check("rst_khz", {31'd0, khz_mode}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        run_one("zero",   32'd0,          32'h00000000, 3'd0, 3'd4, 1'b0);
        run_one("mid",    32'd12345678,   32'h12345678, 3'd0, 3'd4, 1'b0);
        run_one("max8",   32'd99999999,   32'h99999999, 3'd0, 3'd4, 1'b0);
        run_one("min9",   32'd100000000,  32'h10000000, 3'd2, 3'd1, 1'b1);
        run_one("trunc9", 32'd123456789,  32'h12345678, 3'd2, 3'd1, 1'b1);
        run_one("max10",  32'hFFFFFFFF,   32'h42949672, 3'd1, 3'd0, 1'b1);

        // A at E0, B at E5, C at E10: B is overwritten in the pending slot.
        pulse(32'd1000);
        n = 0;
        done_cnt = 0;
        t1 = -1;
        t2 = -1;
        d1 = '0;
        d2 = '0;
        while (n < 110) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin t1 = n; d1 = Disp_Data; end
                if (done_cnt == 2) begin t2 = n; d2 = Disp_Data; end
            end
            if (n == 50) check("pend_hold", Disp_Data, 32'h00001000);
            freq_valid = 1'b0;
            if (n == 4) begin freq_in = 32'd2000; freq_valid = 1'b1; end
            if (n == 9) begin freq_in = 32'd3000; freq_valid = 1'b1; end
            @(negedge Clk);
            n++;
        end
        check("pend_t1", 32'(t1), 32'd34);
        check("pend_d1", d1, 32'h00001000);
        check("pend_gap", 32'(t2 - t1), 32'd35);
        check("pend_d2", d2, 32'h00003000);
        check("pend_count", 32'(done_cnt), 32'd2);

        // Reset mid-conversion discards the value and issues no done.
        pulse(32'd555);
        repeat (9) @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("mrst_data", Disp_Data, 32'h0);
        check("mrst_p2", {29'd0, point_2}, 32'd4);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        Reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge Clk);
        end
        check("mrst_nodone", 32'(done_cnt), 32'd0);
        check("mrst_idle_busy", {31'd0, busy}, 32'd0);

        run_one("after_rst", 32'd7, 32'h00000007, 3'd0, 3'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
